cmp_arbiter: RTL and testbench
==============================

# cmp_arbiter

Round-robin scheduler that shares one `comparator` instance between `NUM_REQ` requesters, such as the branch unit, ALU condition logic and the address-bounds checker. Each requester presents operands and a signed/unsigned select over a valid/ready handshake. The block grants one requester per transaction, registers the operands, and returns a registered flag vector tagged with the requester ID over a single valid/ready response channel. Only one transaction is outstanding at a time, but back-to-back throughput of one result per cycle is sustained when the consumer is always ready.

## Interface
Parameters:
- `WIDTH`, 32, operand width in bits.
- `NUM_REQ`, 4, number of requesters; must be at least 2.
- `ID_W`, `$clog2(NUM_REQ)`, width of the response ID. Derived; never overridden.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit set (one-hot or zero).
- `req_a`  in  `NUM_REQ*WIDTH`  operand A; slice `i` belongs to requester `i`.
- `req_b`  in  `NUM_REQ*WIDTH`  operand B, sliced the same way.
- `req_signed`  in  `NUM_REQ`  1 = signed comparison, 0 = unsigned.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept from the consumer.
- `rsp_id`  out  `ID_W`  index of the requester that owns the response.
- `rsp_flags`  out  6  comparison flags: bit0 eq, bit1 ne, bit2 lt, bit3 le, bit4 gt, bit5 ge.

## Operation
- FSM states: `IDLE` (no response held) and `RESP` (response held on the output).
- `can_accept` = (state == `IDLE`) OR (state == `RESP` AND `rsp_ready`).
- Grant selection (combinational): search `req_valid` starting at `rr_ptr` and wrapping upward; the first set bit wins, giving `grant` (one-hot).
- `req_ready` = `grant` AND `can_accept`, replicated across bits.
- Accept rule: the handshake completes for requester `i` when `req_valid[i]` AND `req_ready[i]`. On accept:
  - latch `a`, `b`, the signed select and `i`;
  - set `rr_ptr` to (`i`+1) mod `NUM_REQ`;
  - state goes to `RESP`.
- Flags are computed by the existing `comparator` module. It is fed with the accept-cycle operands, and its outputs are registered into `rsp_flags`.
- Leaving `RESP`: `RESP` with `rsp_ready` and no new accept goes to `IDLE`. `RESP` with `rsp_ready` and a new accept stays in `RESP` with new contents.
- Output stability: while `rsp_valid` is high and `rsp_ready` is low, `rsp_id` and `rsp_flags` hold stable and `req_ready` is all-zero.
- Requester rules: a requester must hold `req_valid` and its operands until accepted. The block never drops a valid request. Withdrawing a request before acceptance is a protocol violation.
- `rr_ptr` advances only on accept. Idle cycles do not rotate priority.

## Timing
- Latency: accept in cycle N puts `rsp_valid`, `rsp_id` and `rsp_flags` out in cycle N+1.
- Throughput: one result per cycle when `rsp_ready` is held at 1.
- Reset values: `rsp_valid` 0, `rsp_id` 0, `rsp_flags` 0, `rr_ptr` 0, state `IDLE`. `req_ready` is all-zero during reset.
- Reset asserted mid-transaction: the held response is discarded immediately (asynchronous). There is no partial output after release.
- First cycle after reset release: `req_ready` may assert, and requester 0 has top priority.
- Single requester continuously valid: it is granted every cycle that `can_accept` is true.
- All requesters continuously valid: grants rotate 0, 1, …, `NUM_REQ`-1, 0.

## Configuration
- Macro `CMP_ARBITER_MINMAX_EN`.
- When defined:
  - adds ports `rsp_min` and `rsp_max` (out, `WIDTH` each);
  - these are registered alongside `rsp_flags`, computed by `min_max` from the latched operands and signed select;
  - both reset to 0.
- When undefined: the ports and logic are absent, and flag behaviour is identical.

## Structure
- Package `cmp_arbiter_pkg` holds:
  - flag bit index constants `FLG_EQ` through `FLG_GE`;
  - `FLAGS_W` = 6;
  - the state enum type `cmp_arb_state_t` (`IDLE`, `RESP`).
- Sub-module `rr_arbiter` implements the rotating-priority one-hot grant over `NUM_REQ` inputs, given `rr_ptr`, and also outputs the encoded index.
- The top level instantiates `rr_arbiter`, `comparator`, and `min_max` (only when `CMP_ARBITER_MINMAX_EN` is defined).

## Test plan
1. Requester 0, `a`=5, `b`=7, unsigned, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_flags`=0x0E.
2. Requester 2, `a`=0xFFFFFFFF, `b`=1:
   - signed → `rsp_flags`=0x0E;
   - same operands unsigned → `rsp_flags`=0x32.
3. Requester 1, `a`=`b`=0x1234 → `rsp_flags`=0x29, `rsp_id`=1.
4. All four requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0, 1, 2, 3, 0, 1 on consecutive cycles with no bubbles.
5. `rsp_ready` held at 0 for 3 cycles with requests pending → response stable, `req_ready`=0 throughout. On `rsp_ready`=1 the next requester is accepted in the same cycle.
6. `rst` pulsed while in `RESP`:
   - `rsp_valid` drops without waiting for a clock edge;
   - after release, requesters 1 and 3 both valid → requester 1 is granted first (`rr_ptr`=0).

Source files
------------

// File: rtl/cmp_arbiter_pkg.sv
// Shared constants and types for the comparator arbiter: flag bit positions and FSM state.
package cmp_arbiter_pkg;

  localparam int unsigned FLAGS_W = 6;

  localparam int unsigned FLG_EQ = 0;
  localparam int unsigned FLG_NE = 1;
  localparam int unsigned FLG_LT = 2;
  localparam int unsigned FLG_LE = 3;
  localparam int unsigned FLG_GT = 4;
  localparam int unsigned FLG_GE = 5;

  typedef enum logic {
    IDLE,
    RESP
  } cmp_arb_state_t;

endpackage

// File: rtl/comparator.sv
// Combinational signed/unsigned comparator producing the six relational flags.
module comparator
  import cmp_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [FLAGS_W-1:0] flags
);

  logic eq;
  logic lt;

  always_comb begin
    eq = (a == b);
    lt = is_signed ? ($signed(a) < $signed(b)) : (a < b);
    flags         = '0;
    flags[FLG_EQ] = eq;
    flags[FLG_NE] = !eq;
    flags[FLG_LT] = lt;
    flags[FLG_LE] = lt || eq;
    flags[FLG_GT] = !(lt || eq);
    flags[FLG_GE] = !lt;
  end

endmodule

// File: rtl/min_max.sv
// Signed/unsigned minimum and maximum of two operands.
// Only compiled in when CMP_ARBITER_MINMAX_EN is defined.
`ifdef CMP_ARBITER_MINMAX_EN
module min_max #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max
);

  logic lt;

  always_comb begin
    lt  = is_signed ? ($signed(a) < $signed(b)) : (a < b);
    min = lt ? a : b;
    max = lt ? b : a;
  end

endmodule
`endif

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin scheduler sharing one comparator between NUM_REQ requesters.
// Optional feature macro CMP_ARBITER_MINMAX_EN adds registered rsp_min/rsp_max outputs.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_signed,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [FLAGS_W-1:0]       rsp_flags
`ifdef CMP_ARBITER_MINMAX_EN
  ,
  output logic [WIDTH-1:0]         rsp_min,
  output logic [WIDTH-1:0]         rsp_max
`endif
);

  cmp_arb_state_t     state_q, state_d;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               can_accept;
  logic               accept;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_signed;
  logic [FLAGS_W-1:0] cmp_flags;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Comparator sees the granted requester's operands in the accept cycle itself.
  comparator #(
    .WIDTH (WIDTH)
  ) u_comparator (
    .a         (sel_a),
    .b         (sel_b),
    .is_signed (sel_signed),
    .flags     (cmp_flags)
  );

  always_comb begin
    can_accept = (state_q == IDLE) || rsp_ready;
    req_ready  = rst ? '0 : (grant & {NUM_REQ{can_accept}});
    accept     = |(req_valid & req_ready);
    sel_a      = req_a[grant_idx*WIDTH +: WIDTH];
    sel_b      = req_b[grant_idx*WIDTH +: WIDTH];
    sel_signed = req_signed[grant_idx];
    ptr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    rsp_valid  = (state_q == RESP);

    state_d = state_q;
    if (accept) begin
      state_d = RESP;
    end else if ((state_q == RESP) && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      rsp_id    <= '0;
      rsp_flags <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_ptr    <= ptr_next;
        rsp_id    <= grant_idx;
        rsp_flags <= cmp_flags;
      end
    end
  end

`ifdef CMP_ARBITER_MINMAX_EN
  logic [WIDTH-1:0] mm_min;
  logic [WIDTH-1:0] mm_max;

  min_max #(
    .WIDTH (WIDTH)
  ) u_min_max (
    .a         (sel_a),
    .b         (sel_b),
    .is_signed (sel_signed),
    .min       (mm_min),
    .max       (mm_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_min <= '0;
      rsp_max <= '0;
    end else if (accept) begin
      rsp_min <= mm_min;
      rsp_max <= mm_max;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: vector table, scoreboard monitor and hand-written
// sequences for rotation, back-pressure and mid-transaction reset.
module tb_cmp_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_signed;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [5:0]               rsp_flags;
`ifdef CMP_ARBITER_MINMAX_EN
  logic [WIDTH-1:0]         rsp_min;
  logic [WIDTH-1:0]         rsp_max;
`endif

  cmp_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_flags  (rsp_flags)
`ifdef CMP_ARBITER_MINMAX_EN
    ,
    .rsp_min    (rsp_min),
    .rsp_max    (rsp_max)
`endif
  );

  typedef struct {
    int unsigned id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [5:0]  flags;
  } vec_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [5:0]      flags;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference flags via 64-bit arithmetic after explicit sign/zero extension.
  function automatic logic [5:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic s);
    longint va;
    longint vb;
    logic [5:0] f;
    va = s ? longint'($signed(a)) : longint'({32'h0, a});
    vb = s ? longint'($signed(b)) : longint'({32'h0, b});
    f = {va >= vb, va > vb, va <= vb, va < vb, va != vb, va == vb};
    return f;
  endfunction

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sb_unexpected_rsp: got id %0d, expected no response", rsp_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_id", 64'(rsp_id), 64'(e.id));
          check("sb_flags", 64'(rsp_flags), 64'(e.flags));
        end
      end
      check("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: ID_W'(i),
                         flags: model(req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH],
                                      req_signed[i])});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic ok;
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    rsp_ready  = 1'b0;

    vecs[0] = '{0, 32'd5,          32'd7,          1'b0, 6'h0E};
    vecs[1] = '{2, 32'hFFFF_FFFF,  32'd1,          1'b1, 6'h0E};
    vecs[2] = '{2, 32'hFFFF_FFFF,  32'd1,          1'b0, 6'h32};
    vecs[3] = '{1, 32'h0000_1234,  32'h0000_1234,  1'b0, 6'h29};
    vecs[4] = '{3, 32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 6'h0E};
    vecs[5] = '{3, 32'h8000_0000,  32'h7FFF_FFFF,  1'b0, 6'h32};
    vecs[6] = '{0, 32'd0,          32'd0,          1'b1, 6'h29};
    vecs[7] = '{1, 32'd9,          32'd3,          1'b1, 6'h32};

    // Reset state, with requests present to show req_ready stays low.
    #1;
    req_valid = '1;
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table of single transactions.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      req_a[vecs[k].id*WIDTH +: WIDTH] = vecs[k].a;
      req_b[vecs[k].id*WIDTH +: WIDTH] = vecs[k].b;
      req_signed[vecs[k].id]           = vecs[k].sgn;
      req_valid                        = '0;
      req_valid[vecs[k].id]            = 1'b1;
      rsp_ready                        = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (req_ready[vecs[k].id]) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        errors++;
        checks++;
        $display("FAIL vec_accept_timeout: vector %0d never accepted", k);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      check("vec_rsp_valid", 64'(rsp_valid), 64'd1);
      check("vec_rsp_id", 64'(rsp_id), 64'(vecs[k].id));
      check("vec_rsp_flags", 64'(rsp_flags), 64'(vecs[k].flags));
    end

    // All requesters continuously valid: grants rotate with no bubbles.
    pulse_reset();
    req_a[0*WIDTH +: WIDTH] = 32'd0;
    req_a[1*WIDTH +: WIDTH] = 32'd7;
    req_a[2*WIDTH +: WIDTH] = 32'd14;
    req_a[3*WIDTH +: WIDTH] = 32'hFFFF_FFF0;
    req_b      = {4{32'd7}};
    req_signed = 4'b1010;
    rsp_ready  = 1'b1;
    req_valid  = '1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("rot_rsp_valid", 64'(rsp_valid), 64'd1);
      check("rot_rsp_id", 64'(rsp_id), 64'(k % 4));
    end

    // Back-pressure: response holds, no new grants, then same-cycle replacement.
    pulse_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    @(posedge clk);
    #1;
    check("stall_first_valid", 64'(rsp_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_id", 64'(rsp_id), 64'd0);
      check("stall_flags", 64'(rsp_flags),
            64'(model(req_a[31:0], req_b[31:0], req_signed[0])));
      check("stall_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("unstall_req_ready", 64'(req_ready), 64'b0010);
    @(posedge clk);
    #1;
    check("unstall_rsp_id", 64'(rsp_id), 64'd1);

    // Asynchronous reset while a response is held.
    rsp_ready = 1'b0;
    #1;
    rst       = 1'b1;
    req_valid = '0;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("arst_rsp_id", 64'(rsp_id), 64'd0);
    check("arst_rsp_flags", 64'(rsp_flags), 64'd0);
    rst       = 1'b0;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_grant1", 64'(req_ready), 64'b0010);
    @(posedge clk);
    #1;
    check("post_rst_id1", 64'(rsp_id), 64'd1);
    @(negedge clk);
    check("post_rst_grant3", 64'(req_ready), 64'b1000);
    @(posedge clk);
    #1;
    check("post_rst_id3", 64'(rsp_id), 64'd3);
    req_valid = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
